// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types, RV32I opcodes and opcode legality for the multicycle sequencer
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_IMM,
        PC_REG
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4,
        WB_IMM
    } wb_sel_e;

    typedef enum logic [1:0] {
        TC_NONE,
        TC_ILLEGAL,
        TC_IMEM,
        TC_DMEM
    } trap_cause_e;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] funct3;
    } ir_fields_t;

    localparam logic [6:0] OP_R3    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    function automatic logic op_legal(input logic [6:0] op);
        return op inside {OP_R3, OP_IMM, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// ctrl_timeout_cnt: counts cycles spent waiting on a memory and flags the last allowed cycle
module ctrl_timeout_cnt #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int W = $clog2(MEM_TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

    assign expire = en && (cnt == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle sequencer with strobes, memory handshakes, traps and instret
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             br_taken,
    input  logic             halt_req,
    output logic             imem_req,
    input  logic             imem_rvalid,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src_imm,
    output logic             alu_a_pc,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    state_e      state, state_d, bnd;
    trap_cause_e cause_q, cause_d;
    ir_fields_t  ir_q;
    logic        expire;
    logic        unused_f3;
    logic [6:0]  opq;
    logic        is_ld, is_st, is_br, is_jal, is_jalr;

    assign opq       = ir_q.op;
    assign unused_f3 = ^ir_q.funct3;
    assign is_ld     = opq == OP_LD;
    assign is_st     = opq == OP_ST;
    assign is_br     = opq == OP_BR;
    assign is_jal    = opq == OP_JAL;
    assign is_jalr   = opq == OP_JALR;
    assign bnd       = halt_req ? S_HALT : S_FETCH;

    ctrl_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == S_FETCH || state == S_MEM),
        .clr    (state_d != state),
        .expire (expire)
    );

    always_comb begin
        state_d = state;
        cause_d = cause_q;
        case (state)
            S_FETCH:
                if (imem_rvalid)
                    state_d = S_DECODE;
                else if (expire) begin
                    state_d = S_TRAP;
                    cause_d = TC_IMEM;
                end
            S_DECODE:
                if (op_legal(op))
                    state_d = S_EXEC;
                else begin
                    state_d = S_TRAP;
                    cause_d = TC_ILLEGAL;
                end
            S_EXEC:
                state_d = is_br ? bnd : (is_ld || is_st) ? S_MEM : S_WB;
            S_MEM:
                if (dmem_ack)
                    state_d = is_st ? bnd : S_WB;
                else if (expire) begin
                    state_d = S_TRAP;
                    cause_d = TC_DMEM;
                end
            S_WB:
                state_d = bnd;
            S_HALT:
                state_d = halt_req ? S_HALT : S_FETCH;
            default:
                state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            cause_q <= TC_NONE;
            ir_q    <= '0;
            instret <= '0;
        end else begin
            state   <= state_d;
            cause_q <= cause_d;
            if (state == S_DECODE)
                ir_q <= '{op: op, funct3: funct3};
            if (pc_we)
                instret <= instret + CNT_W'(1);
        end
    end

    // requests are gated by rst_n so an outstanding access drops the moment reset asserts
    assign imem_req    = rst_n && state == S_FETCH;
    assign ir_we       = state == S_FETCH && imem_rvalid;
    assign dmem_req    = rst_n && state == S_MEM;
    assign dmem_we     = dmem_req && is_st;
    assign alu_src_imm = state == S_EXEC && (opq inside {OP_IMM, OP_LD, OP_ST, OP_JALR, OP_AUIPC});
    assign alu_a_pc    = state == S_EXEC && opq == OP_AUIPC;
    assign rf_we       = state == S_WB;
    assign pc_we       = (state == S_EXEC && is_br) || (state == S_MEM && is_st && dmem_ack) || state == S_WB;
    assign pc_sel      = (state == S_EXEC && is_br && br_taken) ? PC_IMM :
                         (state == S_WB && is_jal)              ? PC_IMM :
                         (state == S_WB && is_jalr)             ? PC_REG : PC_PLUS4;
    assign wb_sel      = state != S_WB        ? WB_ALU :
                         is_ld                ? WB_MEM :
                         (is_jal || is_jalr)  ? WB_PC4 :
                         opq == OP_LUI        ? WB_IMM : WB_ALU;
    assign halted      = state == S_HALT;
    assign trap        = state == S_TRAP;
    assign trap_cause  = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vectors with a retire scoreboard for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam logic [6:0] R3 = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'h7F;

    typedef struct packed {
        logic        rf;
        logic [1:0]  wb;
        logic [1:0]  pc;
        logic [31:0] ret;
    } exp_t;

    logic        clk, rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        br_taken, halt_req;
    logic        imem_req, imem_rvalid, dmem_req, dmem_we, dmem_ack;
    logic        ir_we, pc_we, rf_we, alu_src_imm, alu_a_pc, halted, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [31:0] instret;

    int   checks = 0, failures = 0;
    int   i_lat, d_lat, iw = 0, dw = 0, ret_model = 0;
    logic i_pend, d_pend;
    exp_t q[$];

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .br_taken(br_taken),
        .halt_req(halt_req), .imem_req(imem_req), .imem_rvalid(imem_rvalid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .alu_src_imm(alu_src_imm), .alu_a_pc(alu_a_pc), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .instret(instret)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // memory responders: answer after i_lat/d_lat wait cycles, never when the latency is negative
    assign imem_rvalid = imem_req && i_lat >= 0 && iw >= i_lat;
    assign dmem_ack    = dmem_req && d_lat >= 0 && dw >= d_lat;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            i_pend = imem_req && !imem_rvalid;
            d_pend = dmem_req && !dmem_ack;
            @(posedge clk);
            #1;
            iw = i_pend ? iw + 1 : 0;
            dw = d_pend ? dw + 1 : 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && pc_we) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: got pc_we=1 expected no retire");
                end else begin
                    e = q.pop_front();
                    chk("sb_rf_we", rf_we, e.rf);
                    chk("sb_wb_sel", wb_sel, e.wb);
                    chk("sb_pc_sel", pc_sel, e.pc);
                    chk("sb_instret", instret, e.ret);
                end
            end
            if (halted || trap)
                chk("idle_strobes", {imem_req, dmem_req, ir_we, pc_we, rf_we}, 0);
        end
    end

    task automatic reset_dut();
        i_lat    = -1;
        d_lat    = -1;
        halt_req = 0;
        rst_n    = 0;
        #1;
        chk("rst_reqs_drop", {imem_req, dmem_req}, 0);
        repeat (2) @(negedge clk);
        rst_n     = 1;
        ret_model = 0;
        #1;
        chk("rst_imem_req", imem_req, 1);
        chk("rst_strobes", {dmem_req, ir_we, pc_we, rf_we, halted, trap}, 0);
        chk("rst_sel", {pc_sel, wb_sel, trap_cause}, 0);
        chk("rst_instret", instret, 0);
    endtask

    task automatic run(input string nm, input logic [6:0] o, input logic bt, input int il,
                       input int dl, input logic rf, input logic [1:0] wb, input logic [1:0] pc,
                       input int lat, input int dreq_exp);
        exp_t e;
        int   n = 0, dreq = 0;
        logic done = 0, imm = 0, apc = 0, bad_we = 0;
        op       = o;
        funct3   = 3'd0;
        br_taken = bt;
        i_lat    = il;
        d_lat    = dl;
        e.rf = rf; e.wb = wb; e.pc = pc; e.ret = ret_model;
        q.push_back(e);
        ret_model++;
        while (!done && n < 200) begin
            n++;
            if (dmem_req) dreq++;
            if (dmem_req && dmem_we != (o == ST)) bad_we = 1;
            imm  |= alu_src_imm;
            apc  |= alu_a_pc;
            done = pc_we;
            if (!done) @(negedge clk);
        end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_dmem_req_cycles"}, dreq, dreq_exp);
        chk({nm, "_dmem_we"}, bad_we, 0);
        chk({nm, "_alu_src_imm"}, imm, o inside {IMM, LD, ST, JALR, AUIPC});
        chk({nm, "_alu_a_pc"}, apc, o == AUIPC);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 0; op = 0; funct3 = 0; br_taken = 0; halt_req = 0; i_lat = -1; d_lat = -1;
        @(negedge clk);
        reset_dut();

        run("addi",  IMM,   0, 0,  0, 1, 2'd0, 2'd0, 4, 0);
        chk("addi_instret", instret, 1);
        run("lw",    LD,    0, 0,  2, 1, 2'd1, 2'd0, 7, 3);
        run("sw",    ST,    0, 0,  0, 0, 2'd0, 2'd0, 4, 1);
        run("beq_t", BR,    1, 0,  0, 0, 2'd0, 2'd1, 3, 0);
        run("beq_n", BR,    0, 0,  0, 0, 2'd0, 2'd0, 3, 0);
        run("jal",   JAL,   0, 0,  0, 1, 2'd2, 2'd1, 4, 0);
        run("jalr",  JALR,  0, 0,  0, 1, 2'd2, 2'd2, 4, 0);
        run("lui",   LUI,   0, 0,  0, 1, 2'd3, 2'd0, 4, 0);
        run("auipc", AUIPC, 0, 0,  0, 1, 2'd0, 2'd0, 4, 0);
        run("add",   R3,    0, 1,  0, 1, 2'd0, 2'd0, 5, 0);
        chk("instret_after_seq", instret, 10);

        halt_req = 1;
        run("jal_halt", JAL, 0, 0, 0, 1, 2'd2, 2'd1, 4, 0);
        chk("halt_entered", {halted, imem_req}, 2'b10);
        repeat (5) @(negedge clk);
        chk("halt_held", halted, 1);
        chk("halt_instret", instret, 11);
        halt_req = 0;
        @(negedge clk);
        chk("halt_exit", {halted, imem_req}, 2'b01);
        run("addi2", IMM, 0, 0, 0, 1, 2'd0, 2'd0, 4, 0);
        chk("instret_after_halt", instret, 12);

        op = LD; i_lat = 0; d_lat = -1;
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_dmem_req_seen", dmem_req, 1);
        repeat (2) @(negedge clk);
        reset_dut();

        op = BAD; i_lat = 0;
        #1;
        chk("illegal_ir_we", ir_we, 1);
        repeat (2) @(negedge clk);
        chk("illegal_trap", {trap, trap_cause}, {1'b1, 2'd1});
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        chk("illegal_imem_quiet", n, 0);
        chk("illegal_trap_sticky", trap, 1);
        reset_dut();

        op = IMM; i_lat = -1;
        n = 0;
        for (int k = 0; k < 40 && !trap; k++) begin
            if (imem_req) n++;
            @(negedge clk);
        end
        chk("imem_timeout_cycles", n, 16);
        chk("imem_timeout_trap", {trap, trap_cause}, {1'b1, 2'd2});
        reset_dut();

        run("addi_late", IMM, 0, 15, 0, 1, 2'd0, 2'd0, 19, 0);
        chk("late_rvalid_no_trap", trap, 0);

        op = LD; i_lat = 0; d_lat = -1;
        n = 0;
        for (int k = 0; k < 60 && !trap; k++) begin
            if (dmem_req) n++;
            @(negedge clk);
        end
        chk("dmem_timeout_cycles", n, 16);
        chk("dmem_timeout_trap", {trap, trap_cause}, {1'b1, 2'd3});
        chk("dmem_timeout_no_retire", instret, 1);
        reset_dut();

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
